// File: rtl/equal_cmp.sv
// Unsigned WIDTH-bit equality comparator: combinational match flag plus registered
// copy, registered per-bit mismatch mask and a saturating match counter.
module equal_cmp #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cnt_clr,
  output logic             out,
  output logic             out_q,
  output logic [WIDTH-1:0] diff_q,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             eq_s;
  logic             cnt_sat_s;
  logic             out_d;
  logic [WIDTH-1:0] diff_d;
  logic [CNT_W-1:0] cnt_d;
  logic             out_r_q;
  logic [WIDTH-1:0] diff_r_q;
  logic [CNT_W-1:0] cnt_q;

  // The primary result has no clock or reset dependence.
  assign eq_s      = (a == b);
  assign out       = eq_s;
  assign cnt_sat_s = &cnt_q;

  // Next-state for the registered copies; clear beats increment, count sticks at all-ones.
  always_comb begin
    out_d  = eq_s;
    diff_d = a ^ b;
    cnt_d  = cnt_q;
    if (cnt_clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (eq_s && !cnt_sat_s) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset taking priority over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r_q  <= 1'b0;
      diff_r_q <= {WIDTH{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      out_r_q  <= out_d;
      diff_r_q <= diff_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_q     = out_r_q;
  assign diff_q    = diff_r_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_equal_cmp.sv
// Self-checking bench for equal_cmp: vector table for the comparator, a scoreboard
// model for the registered outputs, and directed sequences for counter corner cases.
`timescale 1ns/1ps
module tb_equal_cmp;

  logic        clk = 1'b0;
  logic        rst;
  logic        cnt_clr;
  logic [15:0] a;
  logic [15:0] b;
  logic        out, out_q, out2, out_q2;
  logic [15:0] diff_q, diff_q2, match_cnt;
  logic [1:0]  match_cnt2;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        oq;
    logic [15:0] dq;
    logic [15:0] c1;
    logic [1:0]  c2;
  } exp_t;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic        eo;
    logic [15:0] ed;
  } vec_t;

  exp_t        sbq[$];
  logic [15:0] m_cnt;
  logic [1:0]  m_cnt2;

  always #5 clk = ~clk;

  equal_cmp #(.WIDTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cnt_clr(cnt_clr),
    .out(out), .out_q(out_q), .diff_q(diff_q), .match_cnt(match_cnt)
  );

  equal_cmp #(.WIDTH(16), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .a(a), .b(b), .cnt_clr(cnt_clr),
    .out(out2), .out_q(out_q2), .diff_q(diff_q2), .match_cnt(match_cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: predicts the registered outputs from the inputs seen at each edge.
  always @(posedge clk) begin
    exp_t e;
    logic eq;
    eq = (a == b);
    if (rst) begin
      e.oq = 1'b0; e.dq = 16'h0000; e.c1 = 16'h0000; e.c2 = 2'b00;
    end else begin
      e.oq = eq;
      e.dq = a ^ b;
      if (cnt_clr) begin
        e.c1 = 16'h0000; e.c2 = 2'b00;
      end else begin
        e.c1 = (eq && m_cnt  != 16'hFFFF) ? m_cnt  + 16'd1 : m_cnt;
        e.c2 = (eq && m_cnt2 != 2'b11)    ? m_cnt2 + 2'd1  : m_cnt2;
      end
    end
    sbq.push_back(e);
    m_cnt  <= e.c1;
    m_cnt2 <= e.c2;
  end

  // Scoreboard compare, half a cycle after each edge.
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("sb_out_q",      {31'd0, out_q},      {31'd0, e.oq});
      chk("sb_diff_q",     {16'd0, diff_q},     {16'd0, e.dq});
      chk("sb_match_cnt",  {16'd0, match_cnt},  {16'd0, e.c1});
      chk("sb_out_q2",     {31'd0, out_q2},     {31'd0, e.oq});
      chk("sb_match_cnt2", {30'd0, match_cnt2}, {30'd0, e.c2});
    end
  end

  initial begin
    vec_t vt[6];
    vt[0] = '{16'h1234, 16'h1234, 1'b1, 16'h0000};
    vt[1] = '{16'h0000, 16'h8000, 1'b0, 16'h8000};
    vt[2] = '{16'hFFFF, 16'hFFFE, 1'b0, 16'h0001};
    vt[3] = '{16'h5555, 16'hAAAA, 1'b0, 16'hFFFF};
    vt[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0000};
    vt[5] = '{16'h0001, 16'h0000, 1'b0, 16'h0001};

    rst = 1'b1; cnt_clr = 1'b0; a = 16'h0000; b = 16'h0001;
    repeat (2) @(negedge clk);
    chk("reset_out_q", {31'd0, out_q}, 32'd0);
    chk("reset_diff_q", {16'd0, diff_q}, 32'd0);
    chk("reset_match_cnt", {16'd0, match_cnt}, 32'd0);
    rst = 1'b0;

    // Table: combinational result at once, registered copies after the next edge.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a = vt[i].va; b = vt[i].vb;
      #1;
      chk("tbl_out", {31'd0, out}, {31'd0, vt[i].eo});
      @(posedge clk); #1;
      chk("tbl_out_q", {31'd0, out_q}, {31'd0, vt[i].eo});
      chk("tbl_diff_q", {16'd0, diff_q}, {16'd0, vt[i].ed});
    end

    // Out follows b with no clock edge in between.
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFE;
    #1 chk("nc_out_ne", {31'd0, out}, 32'd0);
    b = 16'hFFFF;
    #1 chk("nc_out_eq", {31'd0, out}, 32'd1);

    // Count five matching edges, clear, then reset.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; a = 16'h00FF; b = 16'h00FF;
    repeat (5) @(posedge clk);
    #1 chk("cnt_five", {16'd0, match_cnt}, 32'd5);
    chk("cnt2_sat_at5", {30'd0, match_cnt2}, 32'd3);
    @(negedge clk);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    chk("cnt_clr_beats_inc", {16'd0, match_cnt}, 32'd0);
    @(negedge clk);
    cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("cnt_three", {16'd0, match_cnt}, 32'd3);

    // Reset mid-operation: out keeps tracking, registers clear, counting resumes.
    @(negedge clk);
    rst = 1'b1; b = 16'h00FE;
    #1 chk("rst_out_tracks", {31'd0, out}, 32'd0);
    @(posedge clk); #1;
    chk("rst_out_q", {31'd0, out_q}, 32'd0);
    chk("rst_diff_q", {16'd0, diff_q}, 32'd0);
    chk("rst_match_cnt", {16'd0, match_cnt}, 32'd0);
    @(negedge clk);
    b = 16'h00FF;
    #1 chk("rst_out_eq", {31'd0, out}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("resume_cnt", {16'd0, match_cnt}, 32'd1);

    // Narrow counter saturates at 3 after six matching edges.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("cnt2_sat", {30'd0, match_cnt2}, 32'd3);
    chk("cnt_six", {16'd0, match_cnt}, 32'd6);

    // Random operands every 5 ns, kept 2 ns clear of the clock edges.
    @(negedge clk); #2;
    for (int i = 0; i < 20000; i++) begin
      logic [15:0] ra, rb;
      for (int k = 0; k < 16; k++) begin
        ra[k] = ($urandom_range(15, 0) < 6);
        rb[k] = ($urandom_range(15, 0) < 6);
      end
      if (i % 16 == 0) rb = ra;
      a = ra; b = rb;
      cnt_clr = ($urandom_range(31, 0) == 0);
      #1 chk("rand_out", {31'd0, out}, {31'd0, (ra == rb)});
      #4;
    end
    cnt_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
